// File: rtl/pll_rst_pkg.sv
// Shared types and default timing constants for the PLL lock supervisor.
// The helper sizes counters from the largest relevant cycle parameter.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    QUALIFY   = 3'd1,
    CLR_STDY  = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_LOCK_CYCLES     = 1024;
  localparam int DEF_STDY_RST_CYCLES = 4;
  localparam int DEF_RST_HOLD_CYCLES = 16;
  localparam int DEF_TIMEOUT_CYCLES  = 100000;
  localparam int DEF_CNT_W           = 8;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchroniser with asynchronous active-low clear.
// Used to bring the raw PLL lock flags into the reference clock domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // shift chain; first stage may go metastable, later stages resolve it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_rst_ctrl.sv
// Lock qualification and system-reset sequencer sitting behind the PLL.
// Releases sys_rst_n only after lock has been stable and the steady flag is up.
module pll_rst_ctrl
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int LOCK_CYCLES     = DEF_LOCK_CYCLES,
  parameter int STDY_RST_CYCLES = DEF_STDY_RST_CYCLES,
  parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             pll_lock_stdy,
  output logic             lock_stdy_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic             lock_timeout,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam int CW = $clog2(max_of(max_of(LOCK_CYCLES, STDY_RST_CYCLES), RST_HOLD_CYCLES)) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [CW-1:0]    LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0]    STDY_LAST = CW'(STDY_RST_CYCLES - 1);
  localparam logic [CW-1:0]    HOLD_LAST = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_SAT   = '1;
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [TW-1:0]    TMO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]    TMO_ONE   = TW'(1);
  localparam logic [CNT_W-1:0] LOSS_MAX  = '1;
  localparam logic [CNT_W-1:0] LOSS_ONE  = CNT_W'(1);

  logic             w_lock_s;
  logic             w_stdy_s;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [TW-1:0]    r_tmo;
  logic [TW-1:0]    w_tmo_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic [CNT_W-1:0] r_loss;
  logic [CNT_W-1:0] w_loss_nxt;
  logic             r_stdy_rst;
  logic             r_sys_rst_n;
  logic             r_ready;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (w_lock_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_stdy (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock_stdy),
    .q     (w_stdy_s)
  );

  // next-state and loss accounting; lock loss always wins over counter expiry
  always_comb begin
    w_state_nxt = r_state;
    w_loss_nxt  = r_loss;
    case (r_state)
      WAIT_LOCK: begin
        if (w_lock_s) w_state_nxt = QUALIFY;
        else          w_state_nxt = WAIT_LOCK;
      end
      QUALIFY: begin
        if (!w_lock_s)               w_state_nxt = WAIT_LOCK;
        else if (r_cnt == LOCK_LAST) w_state_nxt = CLR_STDY;
        else                         w_state_nxt = QUALIFY;
      end
      CLR_STDY: begin
        if (!w_lock_s)               w_state_nxt = WAIT_LOCK;
        else if (r_cnt == STDY_LAST) w_state_nxt = HOLD;
        else                         w_state_nxt = CLR_STDY;
      end
      HOLD: begin
        if (!w_lock_s)                            w_state_nxt = WAIT_LOCK;
        else if ((r_cnt >= HOLD_LAST) && w_stdy_s) w_state_nxt = RUN;
        else                                      w_state_nxt = HOLD;
      end
      RUN: begin
        if (!w_lock_s || !w_stdy_s) begin
          w_state_nxt = WAIT_LOCK;
          if (r_loss != LOSS_MAX) w_loss_nxt = r_loss + LOSS_ONE;
          else                    w_loss_nxt = r_loss;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = WAIT_LOCK;
    endcase
  end

  // phase counter restarts on every state change; timeout counter only runs while waiting
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_tmo_nxt     = r_tmo;
    w_timeout_nxt = r_timeout;
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
    else if (r_cnt != CNT_SAT)  w_cnt_nxt = r_cnt + CNT_ONE;
    else                        w_cnt_nxt = r_cnt;

    if (r_state != WAIT_LOCK)
      w_tmo_nxt = '0;
    else if ((w_state_nxt == WAIT_LOCK) && (r_tmo != TMO_LIMIT))
      w_tmo_nxt = r_tmo + TMO_ONE;
    else
      w_tmo_nxt = r_tmo;

    if (w_tmo_nxt == TMO_LIMIT) w_timeout_nxt = 1'b1;
    else                        w_timeout_nxt = r_timeout;
  end

  // state, counters and outputs; outputs track the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_LOCK;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_timeout   <= 1'b0;
      r_loss      <= '0;
      r_stdy_rst  <= 1'b0;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tmo       <= w_tmo_nxt;
      r_timeout   <= w_timeout_nxt;
      r_loss      <= w_loss_nxt;
      r_stdy_rst  <= (w_state_nxt == CLR_STDY);
      r_sys_rst_n <= (w_state_nxt == RUN);
      r_ready     <= (w_state_nxt == RUN);
    end
  end

  assign lock_stdy_rst = r_stdy_rst;
  assign sys_rst_n     = r_sys_rst_n;
  assign ready         = r_ready;
  assign lock_timeout  = r_timeout;
  assign loss_cnt      = r_loss;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Directed bench for pll_rst_ctrl with short timing parameters.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_pll_rst_ctrl;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       pll_lock_stdy;
  logic       lock_stdy_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       lock_timeout;
  logic [3:0] loss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int t_lsr, n_lsr, t_rdy, acc_lsr, acc_rst;

  pll_rst_ctrl #(
    .SYNC_STAGES     (2),
    .LOCK_CYCLES     (8),
    .STDY_RST_CYCLES (2),
    .RST_HOLD_CYCLES (4),
    .TIMEOUT_CYCLES  (20),
    .CNT_W           (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_lock      (pll_lock),
    .pll_lock_stdy (pll_lock_stdy),
    .lock_stdy_rst (lock_stdy_rst),
    .sys_rst_n     (sys_rst_n),
    .ready         (ready),
    .lock_timeout  (lock_timeout),
    .loss_cnt      (loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    pll_lock      = 1'b0;
    pll_lock_stdy = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  // steps until sys_rst_n rises (bounded); reports pulse start/width and release step
  task automatic watch(input int max_steps, output int o_lsr, output int o_nlsr, output int o_rdy);
    o_lsr  = -1;
    o_nlsr = 0;
    o_rdy  = -1;
    for (int i = 1; (i <= max_steps) && (o_rdy < 0); i++) begin
      step();
      if (lock_stdy_rst) begin
        if (o_lsr < 0) o_lsr = i;
        o_nlsr++;
      end
      if (sys_rst_n) o_rdy = i;
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    pll_lock      = 1'b0;
    pll_lock_stdy = 1'b0;
    #2;
    chk("rst_lsr",   32'(lock_stdy_rst), 32'd0);
    chk("rst_sysrn", 32'(sys_rst_n),     32'd0);
    chk("rst_ready", 32'(ready),         32'd0);
    chk("rst_tmo",   32'(lock_timeout),  32'd0);
    chk("rst_loss",  32'(loss_cnt),      32'd0);

    // 1: nominal bring-up, E at step 3
    do_reset();
    pll_lock      = 1'b1;
    pll_lock_stdy = 1'b1;
    watch(40, t_lsr, n_lsr, t_rdy);
    chk("s1_lsr_start", 32'(t_lsr), 32'd11);
    chk("s1_lsr_width", 32'(n_lsr), 32'd2);
    chk("s1_rdy_step",  32'(t_rdy), 32'd17);
    chk("s1_ready",     32'(ready), 32'd1);
    chk("s1_loss",      32'(loss_cnt), 32'd0);

    // 2: glitch during QUALIFY
    do_reset();
    pll_lock_stdy = 1'b1;
    pll_lock      = 1'b1;
    acc_lsr = 0;
    acc_rst = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) pll_lock = 1'b0;
      step();
      acc_lsr += 32'(lock_stdy_rst);
      acc_rst += 32'(sys_rst_n);
    end
    pll_lock = 1'b1;
    chk("s2_glitch_lsr", 32'(acc_lsr), 32'd0);
    chk("s2_glitch_rst", 32'(acc_rst), 32'd0);
    watch(40, t_lsr, n_lsr, t_rdy);
    chk("s2_lsr_start", 32'(t_lsr), 32'd11);
    chk("s2_rdy_step",  32'(t_rdy), 32'd17);
    chk("s2_loss",      32'(loss_cnt), 32'd0);

    // 3: lock loss in RUN
    pll_lock = 1'b0;
    step();
    step();
    chk("s3_sysrn_e2", 32'(sys_rst_n), 32'd1);
    step();
    chk("s3_sysrn_e3", 32'(sys_rst_n), 32'd0);
    chk("s3_ready_e3", 32'(ready),     32'd0);
    chk("s3_loss",     32'(loss_cnt),  32'd1);
    pll_lock = 1'b1;
    watch(40, t_lsr, n_lsr, t_rdy);
    chk("s3_relock_rdy", 32'(t_rdy), 32'd17);
    chk("s3_loss_after", 32'(loss_cnt), 32'd1);

    // 5: steady flag gating in HOLD
    do_reset();
    pll_lock = 1'b1;
    acc_lsr = 0;
    acc_rst = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      acc_lsr += 32'(lock_stdy_rst);
      acc_rst += 32'(sys_rst_n);
    end
    chk("s5_pulse_width", 32'(acc_lsr), 32'd2);
    chk("s5_held_rst",    32'(acc_rst), 32'd0);
    pll_lock_stdy = 1'b1;
    step();
    step();
    chk("s5_sysrn_e2", 32'(sys_rst_n), 32'd0);
    step();
    chk("s5_sysrn_e3", 32'(sys_rst_n), 32'd1);
    chk("s5_ready_e3", 32'(ready),     32'd1);

    // 4: timeout, then loss-counter saturation
    do_reset();
    for (int i = 1; i <= 25; i++) begin
      step();
      if (i == 19) chk("s4_tmo_c19", 32'(lock_timeout), 32'd0);
      if (i == 20) chk("s4_tmo_c20", 32'(lock_timeout), 32'd1);
    end
    pll_lock      = 1'b1;
    pll_lock_stdy = 1'b1;
    watch(40, t_lsr, n_lsr, t_rdy);
    chk("s4_relock_rdy", 32'(t_rdy), 32'd17);
    chk("s4_tmo_sticky", 32'(lock_timeout), 32'd1);
    for (int k = 0; k < 17; k++) begin
      pll_lock = 1'b0;
      if (k == 0) pll_lock_stdy = 1'b0;
      repeat (3) step();
      if (k == 0) chk("s4_both_fall_once", 32'(loss_cnt), 32'd1);
      if (k == 14) chk("s4_loss_15", 32'(loss_cnt), 32'd15);
      pll_lock      = 1'b1;
      pll_lock_stdy = 1'b1;
      watch(40, t_lsr, n_lsr, t_rdy);
    end
    chk("s4_loss_sat", 32'(loss_cnt), 32'd15);
    chk("s4_tmo_end",  32'(lock_timeout), 32'd1);

    // 6: async reset during the lock_stdy_rst pulse
    pll_lock = 1'b0;
    repeat (3) step();
    pll_lock = 1'b1;
    repeat (11) step();
    chk("s6_pulse_on", 32'(lock_stdy_rst), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_lsr",   32'(lock_stdy_rst), 32'd0);
    chk("s6_sysrn", 32'(sys_rst_n),     32'd0);
    chk("s6_ready", 32'(ready),         32'd0);
    chk("s6_loss",  32'(loss_cnt),      32'd0);
    chk("s6_tmo",   32'(lock_timeout),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
